// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB packet transmit sequencer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_PID       = 3'd2,
        ST_DATA      = 3'd3,
        ST_WAIT_LAST = 3'd4,
        ST_WAIT_CRC  = 3'd5,
        ST_IFG       = 3'd6
    } tx_state_e;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam int CRC_WAIT_DEF     = 16;
    localparam int IFG_CYCLES_DEF   = 8;
    localparam int UNDERRUN_MAX_DEF = 4;
    localparam int CNT_W            = 5;

    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_arb.sv
// Two-requester fixed-priority arbiter; handshake wins ties and the
// grant is held until the sequencer releases it.
module usb_tx_arb (
    input  logic clock,
    input  logic reset,
    input  logic hs_req,
    input  logic dat_req,
    input  logic arb_en,
    input  logic gnt_clr,
    output logic hs_win,
    output logic dat_win,
    output logic hs_gnt,
    output logic dat_gnt
);

    logic free;

    assign free    = arb_en & ~hs_gnt & ~dat_gnt;
    assign hs_win  = free & hs_req;
    assign dat_win = free & dat_req & ~hs_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_gnt  <= 1'b0;
            dat_gnt <= 1'b0;
        end else if (gnt_clr) begin
            hs_gnt  <= 1'b0;
            dat_gnt <= 1'b0;
        end else begin
            if (hs_win)
                hs_gnt <= 1'b1;
            if (dat_win)
                dat_gnt <= 1'b1;
        end
    end

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// Packet sequencer in front of the byte-serial USB TX shifter:
// sync, PID, payload, CRC hold-off and inter-packet gap.
module usb_tx_pkt_ctrl
    import usb_tx_pkg::*;
#(
    parameter int CRC_WAIT     = CRC_WAIT_DEF,
    parameter int IFG_CYCLES   = IFG_CYCLES_DEF,
    parameter int UNDERRUN_MAX = UNDERRUN_MAX_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    input  logic       dat_req,
    input  logic [3:0] dat_pid,
    input  logic       dat_zlp,
    input  logic       dat_valid,
    input  logic [7:0] dat_byte,
    input  logic       dat_last,
    output logic       dat_ready,
    output logic       hs_gnt,
    output logic       dat_gnt,
    output logic       hs_done,
    output logic       dat_done,
    output logic       underrun_err,
    input  logic       tx_ready_ld,
    input  logic       halt_tx_shift,
    input  logic       t_lastbit,
    output logic       syn_gen_ld,
    output logic       tx_load,
    output logic [7:0] tx_data,
    output logic       tx_last_byte,
    output logic       crc_16
);

    localparam logic [CNT_W-1:0] CRC_LD = CNT_W'(CRC_WAIT - 1);
    localparam logic [CNT_W-1:0] IFG_LD = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] UND_LD = CNT_W'(UNDERRUN_MAX - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    tx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       pid_q;
    logic             zlp_q;
    logic             abort_q;
    logic             ld_ok;
    logic             hs_win;
    logic             dat_win;
    logic             arb_en;
    logic             gnt_clr;

    assign ld_ok   = tx_ready_ld & ~halt_tx_shift;
    assign arb_en  = (state == ST_IDLE);
    assign gnt_clr = (state == ST_IFG) && (cnt == '0);

    usb_tx_arb u_arb (
        .clock   (clock),
        .reset   (reset),
        .hs_req  (hs_req),
        .dat_req (dat_req),
        .arb_en  (arb_en),
        .gnt_clr (gnt_clr),
        .hs_win  (hs_win),
        .dat_win (dat_win),
        .hs_gnt  (hs_gnt),
        .dat_gnt (dat_gnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pid_q        <= '0;
            zlp_q        <= 1'b0;
            abort_q      <= 1'b0;
            crc_16       <= 1'b0;
            syn_gen_ld   <= 1'b0;
            tx_load      <= 1'b0;
            tx_data      <= 8'h00;
            tx_last_byte <= 1'b0;
            dat_ready    <= 1'b0;
            hs_done      <= 1'b0;
            dat_done     <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            syn_gen_ld   <= 1'b0;
            tx_load      <= 1'b0;
            tx_last_byte <= 1'b0;
            dat_ready    <= 1'b0;
            hs_done      <= 1'b0;
            dat_done     <= 1'b0;
            underrun_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    abort_q <= 1'b0;
                    if (hs_win) begin
                        pid_q  <= hs_pid;
                        zlp_q  <= 1'b0;
                        crc_16 <= 1'b0;
                        state  <= ST_SYNC;
                    end else if (dat_win) begin
                        pid_q  <= dat_pid;
                        zlp_q  <= dat_zlp;
                        crc_16 <= 1'b1;
                        state  <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (ld_ok) begin
                        syn_gen_ld <= 1'b1;
                        state      <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (ld_ok) begin
                        tx_load <= 1'b1;
                        tx_data <= pid_byte(pid_q);
                        if (!crc_16 || zlp_q) begin
                            tx_last_byte <= 1'b1;
                            state        <= ST_WAIT_LAST;
                        end else begin
                            cnt   <= UND_LD;
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (ld_ok && dat_valid) begin
                        tx_load   <= 1'b1;
                        tx_data   <= dat_byte;
                        dat_ready <= 1'b1;
                        cnt       <= UND_LD;
                        if (dat_last) begin
                            tx_last_byte <= 1'b1;
                            cnt          <= '0;
                            state        <= ST_WAIT_LAST;
                        end
                    end else if (ld_ok) begin
                        // Starved load slots count down to an abort
                        if (cnt == '0) begin
                            underrun_err <= 1'b1;
                            abort_q      <= 1'b1;
                            cnt          <= IFG_LD;
                            state        <= ST_IFG;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                end
                ST_WAIT_LAST: begin
                    if (t_lastbit) begin
                        if (crc_16) begin
                            cnt   <= CRC_LD;
                            state <= ST_WAIT_CRC;
                        end else begin
                            cnt   <= IFG_LD;
                            state <= ST_IFG;
                        end
                    end
                end
                ST_WAIT_CRC: begin
                    if (cnt == '0) begin
                        cnt   <= IFG_LD;
                        state <= ST_IFG;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_IFG: begin
                    if (cnt == '0) begin
                        hs_done  <= hs_gnt & ~abort_q;
                        dat_done <= dat_gnt & ~abort_q;
                        crc_16   <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Randomised self-checking bench for usb_tx_pkt_ctrl with a
// packet-level reference model and an emulated shifter/requesters.
module tb_usb_tx_pkt_ctrl;
    import usb_tx_pkg::*;

    localparam int CW = 16;
    localparam int IG = 8;
    localparam int UM = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hs_req = 1'b0;
    logic [3:0] hs_pid = '0;
    logic       dat_req = 1'b0;
    logic [3:0] dat_pid = '0;
    logic       dat_zlp = 1'b0;
    logic       dat_valid = 1'b0;
    logic [7:0] dat_byte = '0;
    logic       dat_last = 1'b0;
    logic       tx_ready_ld = 1'b0;
    logic       halt_tx_shift = 1'b0;
    logic       t_lastbit = 1'b0;
    logic       dat_ready, hs_gnt, dat_gnt, hs_done, dat_done;
    logic       underrun_err, syn_gen_ld, tx_load, tx_last_byte, crc_16;
    logic [7:0] tx_data;

    always #5 clock = ~clock;

    usb_tx_pkt_ctrl #(
        .CRC_WAIT(CW), .IFG_CYCLES(IG), .UNDERRUN_MAX(UM)
    ) dut (
        .clock(clock), .reset(reset),
        .hs_req(hs_req), .hs_pid(hs_pid),
        .dat_req(dat_req), .dat_pid(dat_pid), .dat_zlp(dat_zlp),
        .dat_valid(dat_valid), .dat_byte(dat_byte),
        .dat_last(dat_last), .dat_ready(dat_ready),
        .hs_gnt(hs_gnt), .dat_gnt(dat_gnt),
        .hs_done(hs_done), .dat_done(dat_done),
        .underrun_err(underrun_err),
        .tx_ready_ld(tx_ready_ld), .halt_tx_shift(halt_tx_shift),
        .t_lastbit(t_lastbit), .syn_gen_ld(syn_gen_ld),
        .tx_load(tx_load), .tx_data(tx_data),
        .tx_last_byte(tx_last_byte), .crc_16(crc_16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a packet is a list of fixed loads followed by
    // a payload stream, then timed hold-offs.
    typedef struct {
        bit         sync;
        logic [7:0] b;
        bit         last;
    } item_t;
    typedef enum {P_FREE, P_LOAD, P_LASTBIT, P_CRC, P_GAP} phase_t;

    phase_t     m_ph;
    item_t      m_fixed[$];
    int         m_left, m_starve;
    bit         m_abort;
    logic       e_syn, e_load, e_last, e_ready, e_hsg, e_dg;
    logic       e_hsd, e_dd, e_uerr, e_crc;
    logic [7:0] e_data;

    // Emulated environment
    logic [7:0] pay_q[$];
    logic [7:0] tx_bytes[$];
    logic [8:0] ld_log[$];
    int unsigned rdy_pct = 100, halt_pct = 0, val_pct = 100;
    int cyc = 0, lb_timer = 0, halt_hold = 0, rdy_cnt = 0;
    int lb_edge = -1, hsd_edge = -1, dd_edge = -1, ue_edge = -1;
    int hg_edge = -1, dg_edge = -1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_FREE;
        m_fixed.delete();
        m_left = 0;
        m_starve = 0;
        m_abort = 0;
        {e_syn, e_load, e_last, e_ready, e_hsg} = '0;
        {e_dg, e_hsd, e_dd, e_uerr, e_crc} = '0;
        e_data = 8'h00;
    endtask

    task automatic model_step();
        bit opp;
        item_t it;
        opp = tx_ready_ld && !halt_tx_shift;
        {e_syn, e_load, e_last, e_ready, e_hsd, e_dd, e_uerr} = '0;
        case (m_ph)
            P_FREE: begin
                if (hs_req || dat_req) begin
                    m_fixed.delete();
                    m_fixed.push_back('{1'b1, 8'h00, 1'b0});
                    m_starve = 0;
                    m_ph = P_LOAD;
                    if (hs_req) begin
                        e_hsg = 1; e_crc = 0;
                        m_fixed.push_back('{1'b0, {~hs_pid, hs_pid}, 1'b1});
                    end else begin
                        e_dg = 1; e_crc = 1;
                        m_fixed.push_back('{1'b0, {~dat_pid, dat_pid}, dat_zlp});
                    end
                end
            end
            P_LOAD: if (opp) begin
                if (m_fixed.size() > 0) begin
                    it = m_fixed.pop_front();
                    if (it.sync) e_syn = 1;
                    else begin
                        e_load = 1; e_data = it.b; e_last = it.last;
                        if (it.last) m_ph = P_LASTBIT;
                    end
                end else if (dat_valid) begin
                    e_load = 1; e_data = dat_byte; e_ready = 1;
                    e_last = dat_last; m_starve = 0;
                    if (dat_last) m_ph = P_LASTBIT;
                end else begin
                    m_starve++;
                    if (m_starve == UM) begin
                        e_uerr = 1; m_abort = 1;
                        m_ph = P_GAP; m_left = IG;
                    end
                end
            end
            P_LASTBIT: if (t_lastbit) begin
                m_ph = e_crc ? P_CRC : P_GAP;
                m_left = e_crc ? CW : IG;
            end
            P_CRC: begin
                m_left--;
                if (m_left == 0) begin m_ph = P_GAP; m_left = IG; end
            end
            P_GAP: begin
                m_left--;
                if (m_left == 0) begin
                    if (!m_abort) begin e_hsd = e_hsg; e_dd = e_dg; end
                    e_hsg = 0; e_dg = 0; e_crc = 0;
                    m_abort = 0; m_ph = P_FREE;
                end
            end
            default: m_ph = P_FREE;
        endcase
    endtask

    task automatic check();
        chk("syn_gen_ld", syn_gen_ld, e_syn);
        chk("tx_load", tx_load, e_load);
        chk("tx_last_byte", tx_last_byte, e_last);
        chk("dat_ready", dat_ready, e_ready);
        chk("hs_gnt", hs_gnt, e_hsg);
        chk("dat_gnt", dat_gnt, e_dg);
        chk("hs_done", hs_done, e_hsd);
        chk("dat_done", dat_done, e_dd);
        chk("underrun_err", underrun_err, e_uerr);
        chk("crc_16", crc_16, e_crc);
        if (e_load) chk("tx_data", tx_data, e_data);
    endtask

    task automatic src_drive();
        dat_valid = pay_q.size() > 0 && $urandom_range(0, 99) < val_pct;
        dat_byte = pay_q.size() > 0 ? pay_q[0] : 8'($urandom);
        dat_last = pay_q.size() == 1;
    endtask

    task automatic react();
        if (dat_ready) begin
            rdy_cnt++;
            if (pay_q.size() > 0) void'(pay_q.pop_front());
        end
        if (tx_load) ld_log.push_back({tx_last_byte, tx_data});
        if (hs_done) begin hs_req = 0; hsd_edge = cyc; end
        if (dat_done) begin dat_req = 0; dd_edge = cyc; end
        if (underrun_err) begin dat_req = 0; ue_edge = cyc; end
        if (hs_gnt && hg_edge < 0) hg_edge = cyc;
        if (dat_gnt && dg_edge < 0) dg_edge = cyc;
        t_lastbit = 0;
        if (lb_timer > 0) begin
            lb_timer--;
            if (lb_timer == 0) t_lastbit = 1;
        end
        if (tx_last_byte) lb_timer = $urandom_range(2, 6);
        if (halt_hold > 0) begin
            halt_hold--;
            halt_tx_shift = 1; tx_ready_ld = 1;
        end else begin
            tx_ready_ld = $urandom_range(0, 99) < rdy_pct;
            halt_tx_shift = $urandom_range(0, 99) < halt_pct;
        end
        src_drive();
    endtask

    task automatic cycle();
        @(posedge clock);
        cyc++;
        if (t_lastbit) lb_edge = cyc;
        model_step();
        #1;
        check();
        react();
    endtask

    task automatic send_hs(input logic [3:0] pid, input logic [7:0] exp_b);
        int n = 0;
        ld_log.delete(); hsd_edge = -1; lb_edge = -1;
        hs_pid = pid; hs_req = 1;
        while (hsd_edge < 0 && n < 3000) begin cycle(); n++; end
        if (hsd_edge < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL hs_timeout: no hs_done after %0d cycles", n);
        end else begin
            chk("hs_nloads", ld_log.size(), 1);
            if (ld_log.size() > 0) begin
                chk("hs_pid_byte", ld_log[0][7:0], exp_b);
                chk("hs_last", ld_log[0][8], 1);
            end
            chk("hs_done_lat", hsd_edge - lb_edge, IG);
        end
    endtask

    // want: 0 any outcome, 1 must complete, 2 must underrun
    task automatic send_dat(input logic [3:0] pid, input bit zlp,
                            input logic [7:0] exp_pid, input int want,
                            input int halt_after);
        int n = 0;
        bit halted = 0;
        logic [7:0] eb;
        ld_log.delete(); rdy_cnt = 0;
        dd_edge = -1; ue_edge = -1; lb_edge = -1;
        pay_q = tx_bytes;
        dat_pid = pid; dat_zlp = zlp; dat_req = 1;
        src_drive();
        while (dd_edge < 0 && ue_edge < 0 && n < 3000) begin
            cycle(); n++;
            if (halt_after > 0 && !halted && ld_log.size() == halt_after) begin
                halted = 1; halt_hold = 4;
                halt_tx_shift = 1; tx_ready_ld = 1;
            end
        end
        if (dd_edge < 0 && ue_edge < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL dat_timeout: no done/underrun after %0d cycles", n);
            return;
        end
        if (want != 0) chk("dat_outcome", ue_edge >= 0, want == 2);
        if (ue_edge >= 0) begin
            while (dat_gnt && n < 3000) begin cycle(); n++; end
            chk("uerr_gap", cyc - ue_edge, IG);
            chk("uerr_no_done", dd_edge, -1);
        end else begin
            chk("dat_nloads", ld_log.size(), tx_bytes.size() + 1);
            for (int i = 0; i < ld_log.size(); i++) begin
                eb = (i == 0) ? exp_pid :
                     (i - 1 < tx_bytes.size()) ? tx_bytes[i-1] : 8'hxx;
                chk("dat_byte_seq", ld_log[i][7:0], eb);
                chk("dat_last_pos", ld_log[i][8], i == ld_log.size() - 1);
            end
            chk("dat_ready_cnt", rdy_cnt, tx_bytes.size());
            chk("dat_done_lat", dd_edge - lb_edge, CW + IG);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] hp [3];
        hp = '{PID_ACK, PID_NAK, PID_STALL};
        model_reset();
        #12;
        check();
        chk("rst_tx_data", tx_data, 8'h00);
        #10 reset = 1;

        // Directed: ACK, DATA0 x3, halt, tie-break, starve, ZLP
        send_hs(PID_ACK, 8'hD2);
        tx_bytes = '{8'h11, 8'h22, 8'h33};
        send_dat(PID_DATA0, 0, 8'hC3, 1, 0);
        tx_bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        send_dat(PID_DATA0, 0, 8'hC3, 1, 2);

        tx_bytes = '{8'h5A, 8'hA5};
        pay_q = tx_bytes; ld_log.delete();
        hg_edge = -1; dg_edge = -1; hsd_edge = -1; dd_edge = -1;
        hs_pid = PID_NAK; dat_pid = PID_DATA1; dat_zlp = 0;
        hs_req = 1; dat_req = 1; src_drive();
        n = 0;
        while (dd_edge < 0 && n < 3000) begin cycle(); n++; end
        chk("tie_hs_first", hg_edge >= 0 && hg_edge < dg_edge, 1);
        chk("tie_dat_after_done", dg_edge, hsd_edge + 1);
        if (ld_log.size() > 1) begin
            chk("tie_nak_byte", ld_log[0][7:0], 8'h5A);
            chk("tie_data1_byte", ld_log[1][7:0], 8'h4B);
        end

        tx_bytes.delete();
        send_dat(PID_DATA1, 0, 8'h4B, 2, 0);
        send_dat(PID_DATA1, 1, 8'h4B, 1, 0);

        // Random traffic with a stalling shifter and bursty payload
        for (int k = 0; k < 40; k++) begin
            int len;
            rdy_pct = $urandom_range(30, 100);
            halt_pct = $urandom_range(0, 30);
            val_pct = $urandom_range(50, 100);
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(0, 2);
                send_hs(hp[n], {~hp[n], hp[n]});
            end else begin
                len = $urandom_range(0, 6);
                tx_bytes.delete();
                for (int j = 0; j < len; j++) tx_bytes.push_back(8'($urandom));
                if (k[0]) send_dat(PID_DATA1, len == 0, 8'h4B, 0, 0);
                else send_dat(PID_DATA0, len == 0, 8'hC3, 0, 0);
            end
        end

        // Asynchronous reset in the middle of a data packet
        rdy_pct = 100; halt_pct = 0; val_pct = 100;
        tx_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        pay_q = tx_bytes; ld_log.delete();
        dat_pid = PID_DATA0; dat_zlp = 0; dat_req = 1; src_drive();
        n = 0;
        while (ld_log.size() < 3 && n < 200) begin cycle(); n++; end
        chk("rst_reached_data", ld_log.size(), 3);
        #2 reset = 0;
        #1;
        chk("rst_tx_load", tx_load, 0);
        chk("rst_tx_data_async", tx_data, 8'h00);
        chk("rst_dat_gnt", dat_gnt, 0);
        chk("rst_crc_16", crc_16, 0);
        chk("rst_dat_ready", dat_ready, 0);
        model_reset();
        hs_req = 0; dat_req = 0; pay_q.delete();
        lb_timer = 0; t_lastbit = 0; src_drive();
        @(posedge clock);
        @(posedge clock);
        #1;
        check();
        #3 reset = 1;
        send_hs(PID_STALL, 8'h1E);
        send_hs(PID_ACK, 8'hD2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_tx_pkt_ctrl.md
Name: usb_tx_pkt_ctrl

Overview:
Packet-level transmit sequencer and arbiter in front of the byte-serial USB TX shifter. It arbitrates between a handshake requester (PID-only ACK/NAK/STALL) and a data requester (DATA0/DATA1 plus payload). It then drives the shifter's sync-load, byte-load, last-byte and CRC-mode controls for the granted packet. It enforces the end-of-packet CRC wait and the inter-packet gap before accepting a new request.

Parameters:
CRC_WAIT, 16, clock cycles held after t_lastbit for data packets so the shifter can emit CRC16
IFG_CYCLES, 8, idle clock cycles after the packet before returning to IDLE
UNDERRUN_MAX, 4, consecutive cycles with tx_ready_ld=1 and no payload byte before the packet is aborted

Ports:
clock  in  1  global chip clock, rising edge
reset  in  1  asynchronous, active-low reset
hs_req  in  1  handshake packet request; held until hs_done
hs_pid  in  4  handshake PID, sampled at grant
dat_req  in  1  data packet request; held until dat_done
dat_pid  in  4  DATA0/DATA1 PID, sampled at grant
dat_zlp  in  1  zero-length data packet, sampled at grant
dat_valid  in  1  payload byte available
dat_byte  in  8  payload byte
dat_last  in  1  current payload byte is the final byte
dat_ready  out  1  payload byte consumed this cycle
hs_gnt  out  1  handshake requester owns the transmitter
dat_gnt  out  1  data requester owns the transmitter
hs_done  out  1  one-cycle pulse at end of the handshake packet
dat_done  out  1  one-cycle pulse at end of the data packet
underrun_err  out  1  one-cycle pulse when a data packet is aborted on starvation
tx_ready_ld  in  1  shifter can accept a load this cycle
halt_tx_shift  in  1  shifter halted for bit stuffing
t_lastbit  in  1  shifter has sent the last bit of the final byte
syn_gen_ld  out  1  load the sync pattern
tx_load  out  1  load tx_data into the shifter
tx_data  out  8  byte presented to the shifter
tx_last_byte  out  1  byte loaded this cycle is the packet's final byte
crc_16  out  1  CRC mode to the shifter: 1 = CRC16 (data packet), 0 = no/5-bit CRC

Behaviour:
- Reset (reset=0, asynchronous): state returns to IDLE and all outputs are 0, including tx_data=8'h00. An abort mid-packet is silent: no done pulse and no error pulse.
- All outputs are registered. A load decision made in cycle N appears on tx_load/tx_data in cycle N+1.
- A load is issued only in a cycle where tx_ready_ld=1 and halt_tx_shift=0. At most one syn_gen_ld or tx_load is issued per cycle, and the two are never asserted together.
- FSM states: IDLE, SYNC, PID, DATA, WAIT_LAST, WAIT_CRC, IFG.
- IDLE:
  - hs_req has fixed priority over dat_req; simultaneous requests grant hs.
  - On grant, latch the PID (and dat_zlp for data), set the gnt output, set crc_16 = dat_gnt, then go to SYNC.
  - gnt and crc_16 stay stable until the done pulse.
- SYNC: on a load opportunity, pulse syn_gen_ld, then go to PID.
- PID: on a load opportunity, pulse tx_load with tx_data = {~pid, pid}.
  - Handshake or zero-length data: also assert tx_last_byte, then go to WAIT_LAST.
  - Otherwise go to DATA.
- DATA:
  - On a load opportunity with dat_valid=1: pulse tx_load, drive tx_data = dat_byte, pulse dat_ready in the same cycle, and clear the underrun counter.
  - If dat_last=1, also assert tx_last_byte and go to WAIT_LAST.
  - On a load opportunity with dat_valid=0: increment the underrun counter. When it reaches UNDERRUN_MAX, pulse underrun_err and go to IFG. No tx_last_byte is issued and no dat_done is pulsed; the data requester drops dat_req.
- WAIT_LAST: on the first cycle of t_lastbit=1, go to WAIT_CRC if crc_16=1, else go to IFG.
- WAIT_CRC: count CRC_WAIT cycles, then go to IFG.
- IFG:
  - Count IFG_CYCLES cycles.
  - On the last count, pulse hs_done or dat_done, clear the gnt and crc_16 outputs, and return to IDLE.
  - A new grant is possible the cycle after the done pulse.
- Counters (underrun, CRC, IFG):
  - One shared 5-bit down-counter, cleared on every state entry.
  - The counter is not frozen by halt_tx_shift, because the shifter's CRC timing is not halted either.
- A request that drops while granted is ignored; the packet completes normally.

Decomposition:
- Shared package usb_tx_pkg holds:
  - FSM state encodings (3-bit).
  - PID constants: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110, DATA0 4'b0011, DATA1 4'b1011.
  - Parameter defaults.
- One sub-module: usb_tx_arb, a two-requester fixed-priority arbiter that holds the grant until release. The FSM and counter stay in the top level.

Test Plan:
- Handshake ACK: hs_req with hs_pid=4'b0010. Expect one syn_gen_ld, then tx_load with tx_data=8'hD2 and tx_last_byte=1, crc_16=0. After t_lastbit, hs_done follows IFG_CYCLES=8 cycles later.
- DATA0 with 3 payload bytes 8'h11/8'h22/8'h33, dat_last on 8'h33. Expect PID byte 8'hC3, then the three bytes in order, each with dat_ready, and tx_last_byte only with 8'h33. crc_16=1 throughout. dat_done follows 16+8 cycles after t_lastbit.
- hs_req and dat_req asserted in the same cycle: hs_gnt=1 first. dat_gnt rises the cycle after hs_done, and no load overlaps.
- halt_tx_shift=1 for 5 cycles in DATA with tx_ready_ld=1: no tx_load or dat_ready during the halt, and no byte is lost or duplicated after release.
- DATA1 with dat_valid held 0: underrun_err pulses after 4 load opportunities, the FSM returns to IDLE after 8 IFG cycles, and no dat_done is pulsed. A zero-length DATA1 (dat_zlp=1) instead gives a single tx_load 8'h4B with tx_last_byte=1.
- reset driven 0 during DATA: all outputs are 0 immediately, without waiting for a clock edge. After release, a new hs_req completes normally.
